aes_ks_inv: RTL
===============

AES_KS_INV -- requirements
Module: aes_ks_inv

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port load_i, input, 1 bit: single-cycle pulse; samples key_i and starts expansion.
REQ-004 SHALL have port key_i, input, 128 bits: AES-128 cipher key, word w0 = bits [127:96].
REQ-005 SHALL have port next_i, input, 1 bit: request for the next lower round key.
REQ-006 SHALL have port ks_o, output, 128 bits: current round key, registered.
REQ-007 SHALL have port round_o, output, 4 bits: round index of ks_o, range 0..10.
REQ-008 SHALL have port busy_o, output, 1 bit: forward expansion in progress.
REQ-009 SHALL have port ready_o, output, 1 bit: ks_o valid for reverse-order consumption.

Function
REQ-010 SHALL implement states IDLE, FWD and REV, with ready_o = (state == REV) and busy_o = (state == FWD).
REQ-011 SHALL, on load_i in any state, load ks_o <= key_i and round_o <= 0, and enter FWD on the next edge.
REQ-012 SHALL, in FWD, perform one forward step per cycle: n0 = w0 ^ SubWord(RotWord(w3)) ^ Rcon[r+1], n1 = w1 ^ n0, n2 = w2 ^ n1, n3 = w3 ^ n2; round_o increments.
REQ-013 SHALL enter REV on the same edge at which round_o becomes 10.
REQ-014 SHALL therefore raise ready_o exactly 10 cycles after the cycle in which load_i is sampled, with ks_o = round-10 key.
REQ-015 SHALL, in REV with next_i = 1 and round_o > 0, replace the key by the previous one on the next edge (p3 = w3 ^ w2, p2 = w2 ^ w1, p1 = w1 ^ w0, p0 = w0 ^ SubWord(RotWord(p3)) ^ Rcon[r]) and decrement round_o.
REQ-016 SHALL ignore next_i when round_o == 0; ks_o then holds the cipher key and the state remains REV.
REQ-017 SHALL ignore next_i in IDLE and FWD.
REQ-018 SHALL use Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36 (placed in the MSB byte of the word).
REQ-019 SHALL share one set of 4 forward S-boxes (dec tied 0) between the FWD and REV steps; all outputs come directly from registers.
REQ-020 SHALL give load_i priority over next_i in the same cycle; a load during FWD or REV aborts the current expansion and restarts it.
REQ-021 SHALL accept back-to-back next_i, giving one key per cycle, so 10 consecutive pulses reach round 0 in 10 cycles.

Reset
REQ-022 SHALL, while rst is high on a clock edge, set state = IDLE, ks_o = 0, round_o = 0, busy_o = 0, ready_o = 0.
REQ-023 SHALL give rst priority over load_i and next_i; rst mid-FWD or mid-REV discards all progress.
REQ-024 SHALL, after reset, hold all outputs until load_i is sampled.

Verification
REQ-025 SHALL be verified as follows: load key 2b7e151628aed2a6abf7158809cf4f3c -> busy_o for 10 cycles, then ready_o = 1, round_o = 10, ks_o = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-026 SHALL be verified as follows: from REQ-025, one next_i -> round_o = 9, ks_o = ac7766f319fadc2128d12941575c006e.
REQ-027 SHALL be verified as follows: 10 consecutive next_i, then 3 more -> round_o = 0, ks_o = 2b7e151628aed2a6abf7158809cf4f3c, held; each intermediate key matches the FIPS-197 A.1 schedule.
REQ-028 SHALL be verified as follows: load_i at FWD cycle 5 with key 000102030405060708090a0b0c0d0e0f -> 10 cycles later ks_o = 13111d7fe3944a17f307a78b4d2b30c5, round_o = 10.
REQ-029 SHALL be verified as follows: rst asserted together with load_i, then rst asserted in REV with next_i high -> all outputs 0 and state IDLE on the following cycle.
REQ-030 SHALL be verified as follows: next_i during FWD and in IDLE -> no change to round_o or ks_o; random keys compared against the reference model over 1000 loads.

Source files
------------

// File: rtl/aes_ks_inv.sv
// AES-128 key schedule with reverse-order read-out for decryption.
//
// A load captures the cipher key and steps the schedule forward once per cycle
// until the round-10 key is held. After that, each next_i request steps the key
// back by one round, so a decryptor can consume round keys 10, 9, ..., 0.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - synchronous active-high reset
//   load_i   - single-cycle pulse: sample key_i and start forward expansion
//   key_i    - 128-bit cipher key, word w0 = key_i[127:96]
//   next_i   - request the next lower round key (honoured only when ready)
//   ks_o     - current round key (registered)
//   round_o  - round index of ks_o, 0..10 (registered)
//   busy_o   - forward expansion in progress (registered)
//   ready_o  - ks_o valid for reverse-order consumption (registered)
module aes_ks_inv (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [127:0] key_i,
  input  logic         next_i,
  output logic [127:0] ks_o,
  output logic [3:0]   round_o,
  output logic         busy_o,
  output logic         ready_o
);

  typedef enum logic [1:0] {StIdle, StFwd, StRev} state_e;

  state_e       state_q, state_d;
  logic [127:0] ks_q, ks_d;
  logic [3:0]   round_q, round_d;
  logic         busy_q, busy_d;
  logic         ready_q, ready_d;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse as a^254 (0 maps to 0), then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x14, x15, x240, inv;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x14  = gf_mul(x12, x2);
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(x240, x14);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sub_in, rot_in, t_word;
  logic [3:0]   rcon_idx;
  logic [31:0]  n0, n1, n2, n3;
  logic [31:0]  p0, p1, p2, p3;

  // One S-box word shared by both directions: forward uses w3, reverse uses the
  // recovered previous w3 (= w3 ^ w2).
  always_comb begin
    w0       = ks_q[127:96];
    w1       = ks_q[95:64];
    w2       = ks_q[63:32];
    w3       = ks_q[31:0];
    sub_in   = (state_q == StRev) ? (w3 ^ w2) : w3;
    rot_in   = {sub_in[23:0], sub_in[31:24]};
    rcon_idx = (state_q == StRev) ? round_q : (round_q + 4'd1);
    t_word   = {sbox(rot_in[31:24]), sbox(rot_in[23:16]), sbox(rot_in[15:8]),
                sbox(rot_in[7:0])} ^ {rcon(rcon_idx), 24'h000000};
    n0 = w0 ^ t_word;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    p0 = w0 ^ t_word;
  end

  always_comb begin
    state_d = state_q;
    ks_d    = ks_q;
    round_d = round_q;
    if (load_i) begin
      ks_d    = key_i;
      round_d = 4'd0;
      state_d = StFwd;
    end else begin
      case (state_q)
        StIdle: ;
        StFwd: begin
          ks_d    = {n0, n1, n2, n3};
          round_d = round_q + 4'd1;
          if (round_q == 4'd9) state_d = StRev;
        end
        StRev: begin
          if (next_i && (round_q != 4'd0)) begin
            ks_d    = {p0, p1, p2, p3};
            round_d = round_q - 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    // Flags are registered alongside the state so outputs come straight from flops.
    busy_d  = (state_d == StFwd);
    ready_d = (state_d == StRev);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ks_q    <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ks_q    <= ks_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign ks_o    = ks_q;
  assign round_o = round_q;
  assign busy_o  = busy_q;
  assign ready_o = ready_q;

endmodule
